// File: rtl/cpu_debug_pkg.sv
// Shared types and JDO field offsets for the CPU debug OCI RAM arbiter slice.
package cpu_debug_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
    typedef enum logic {GrantCpu, GrantJtag} grant_e;
    typedef enum logic {JtagRead, JtagWrite} jtag_op_e;

    localparam int unsigned ADDR_LSB  = 17;
    localparam int unsigned READ_BIT  = 34;
    localparam int unsigned WDATA_MSB = 34;
    localparam int unsigned WDATA_LSB = 3;

endpackage

// File: rtl/cpu_debug_ociram_arbiter_if.sv
// CPU-side request/ack bus into the OCI RAM arbiter.
interface cpu_debug_ociram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_byteen;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/cpu_debug_jtag_cmd_latch.sv
// Decodes JTAG ocimem strobes into a single pending command and tracks the JTAG address pointer.
module cpu_debug_jtag_cmd_latch
    import cpu_debug_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned JDO_W  = 38
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              take_action_ocimem_a_i,
    input  logic              take_action_ocimem_b_i,
    input  logic              take_no_action_ocimem_a_i,
    input  logic [JDO_W-1:0]  jdo_i,
    input  logic              consume_i,
    output logic              strobe_o,
    output logic              pend_valid_o,
    output jtag_op_e          pend_op_o,
    output logic [ADDR_W-1:0] pend_addr_o,
    output logic [DATA_W-1:0] pend_data_o,
    output logic              overrun_o
);

    logic              pend_valid_q, pend_valid_d;
    jtag_op_e          pend_op_q, pend_op_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] base_addr;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo_i[JDO_W-1:WDATA_MSB+1], jdo_i[WDATA_LSB-1:0]};
    assign strobe_o   = take_action_ocimem_a_i | take_action_ocimem_b_i |
                        take_no_action_ocimem_a_i;

    // A command landing in the same cycle as an issue must already see the bumped address.
    assign base_addr = consume_i ? pend_addr_q + ADDR_W'(1) : jtag_addr_q;

    always_comb begin
        pend_valid_d = pend_valid_q & ~consume_i;
        pend_op_d    = pend_op_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        jtag_addr_d  = base_addr;
        overrun_d    = overrun_q | (strobe_o & pend_valid_q);
        if (take_action_ocimem_a_i) begin
            jtag_addr_d = jdo_i[ADDR_LSB +: ADDR_W];
            if (jdo_i[READ_BIT]) begin
                pend_valid_d = 1'b1;
                pend_op_d    = JtagRead;
                pend_addr_d  = jdo_i[ADDR_LSB +: ADDR_W];
            end
        end else if (take_action_ocimem_b_i) begin
            pend_valid_d = 1'b1;
            pend_op_d    = JtagWrite;
            pend_addr_d  = base_addr;
            pend_data_d  = DATA_W'(jdo_i[WDATA_MSB:WDATA_LSB]);
        end else if (take_no_action_ocimem_a_i) begin
            pend_valid_d = 1'b1;
            pend_op_d    = JtagRead;
            pend_addr_d  = base_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= JtagRead;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            jtag_addr_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            jtag_addr_q  <= jtag_addr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_op_o    = pend_op_q;
    assign pend_addr_o  = pend_addr_q;
    assign pend_data_o  = pend_data_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/cpu_debug_ociram_arbiter.sv
// Round-robin sharing of the single-port OCI RAM between the JTAG debug host and the CPU monitor.
module cpu_debug_ociram_arbiter
    import cpu_debug_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned JDO_W  = 38
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        take_action_ocimem_a,
    input  logic                        take_action_ocimem_b,
    input  logic                        take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]            jdo,
    cpu_debug_ociram_arbiter_if.slave   cpu,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic [3:0]                  ram_byteen,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic [DATA_W-1:0]           MonDReg,
    output logic                        monitor_ready,
    output logic                        jtag_overrun
);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_byteen_q, ram_byteen_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
    logic              monitor_ready_q, monitor_ready_d;
    logic              consume, pick_jtag, complete;
    logic              jtag_strobe, pend_valid;
    jtag_op_e          pend_op;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    cpu_debug_jtag_cmd_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .JDO_W  (JDO_W)
    ) u_cmd_latch (
        .clk_i                     (clk),
        .reset_i                   (reset),
        .take_action_ocimem_a_i    (take_action_ocimem_a),
        .take_action_ocimem_b_i    (take_action_ocimem_b),
        .take_no_action_ocimem_a_i (take_no_action_ocimem_a),
        .jdo_i                     (jdo),
        .consume_i                 (consume),
        .strobe_o                  (jtag_strobe),
        .pend_valid_o              (pend_valid),
        .pend_op_o                 (pend_op),
        .pend_addr_o               (pend_addr),
        .pend_data_o               (pend_data),
        .overrun_o                 (jtag_overrun)
    );

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        ram_en_d        = 1'b0;
        ram_we_d        = 1'b0;
        ram_addr_d      = '0;
        ram_wdata_d     = '0;
        ram_byteen_d    = '0;
        cpu_ack_d       = 1'b0;
        cpu_rdata_d     = cpu_rdata_q;
        mon_dreg_d      = mon_dreg_q;
        monitor_ready_d = monitor_ready_q & ~jtag_strobe;
        consume         = 1'b0;
        pick_jtag       = 1'b0;
        complete        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu.cpu_req || pend_valid) begin
                    // Under contention the requester not served last time wins.
                    pick_jtag    = pend_valid && (!cpu.cpu_req || last_grant_q == GrantCpu);
                    grant_d      = pick_jtag ? GrantJtag : GrantCpu;
                    last_grant_d = grant_d;
                    state_d      = StIssue;
                    ram_en_d     = 1'b1;
                    if (pick_jtag) begin
                        consume      = 1'b1;
                        ram_we_d     = (pend_op == JtagWrite);
                        ram_addr_d   = pend_addr;
                        ram_wdata_d  = pend_data;
                        ram_byteen_d = 4'hF;
                    end else begin
                        ram_we_d     = cpu.cpu_we;
                        ram_addr_d   = cpu.cpu_addr;
                        ram_wdata_d  = cpu.cpu_wdata;
                        ram_byteen_d = cpu.cpu_byteen;
                    end
                end
            end
            StIssue: begin
                if (ram_we_q) begin
                    state_d  = StDone;
                    complete = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                state_d  = StDone;
                complete = 1'b1;
                if (grant_q == GrantCpu) cpu_rdata_d = ram_rdata;
                else                     mon_dreg_d  = ram_rdata;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A fresh JTAG strobe keeps monitor_ready low even if an older op finishes now.
        if (complete) begin
            if (grant_q == GrantCpu) cpu_ack_d       = 1'b1;
            else                     monitor_ready_d = ~jtag_strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            grant_q         <= GrantCpu;
            last_grant_q    <= GrantCpu;
            ram_en_q        <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
            ram_byteen_q    <= '0;
            cpu_ack_q       <= 1'b0;
            cpu_rdata_q     <= '0;
            mon_dreg_q      <= '0;
            monitor_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            ram_en_q        <= ram_en_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_byteen_q    <= ram_byteen_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_rdata_q     <= cpu_rdata_d;
            mon_dreg_q      <= mon_dreg_d;
            monitor_ready_q <= monitor_ready_d;
        end
    end

    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_byteen    = ram_byteen_q;
    assign cpu.cpu_ack   = cpu_ack_q;
    assign cpu.cpu_rdata = cpu_rdata_q;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = monitor_ready_q;

endmodule

// File: tb/tb_cpu_debug_ociram_arbiter.sv
// Directed + randomized bench: behavioural RAM/arbitration model checked with immediate assertions.
module tb_cpu_debug_ociram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [37:0] jdo = '0;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata, MonDReg;
    logic [3:0]  ram_byteen;
    logic        monitor_ready, jtag_overrun;

    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  acc_addr [$];
    logic        acc_we [$];
    logic [31:0] acc_data [$];

    logic [7:0]  m_jaddr;
    logic        m_last_jtag;
    int          tests = 0;
    int          failed = 0;

    cpu_debug_ociram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) cpu_bus ();

    cpu_debug_ociram_arbiter #(.ADDR_W(8), .DATA_W(32), .JDO_W(38)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .cpu                     (cpu_bus),
        .ram_en                  (ram_en),
        .ram_we                  (ram_we),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_byteen              (ram_byteen),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    // Single-port RAM with 1-cycle read latency plus an access log.
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
            acc_addr.push_back(ram_addr);
            acc_we.push_back(ram_we);
            acc_data.push_back(ram_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic acc_clear();
        acc_addr.delete();
        acc_we.delete();
        acc_data.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_jaddr = 8'h00;
        m_last_jtag = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        step();
        load_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic rand_jdo();
        logic [63:0] r;
        r = {$urandom, $urandom};
        jdo = r[37:0];
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action read-next. Starts and ends with FSM idle.
    task automatic jtag_cmd(input int kind, input logic [7:0] addr, input logic rd,
                            input logic [31:0] data, input string tag);
        logic [7:0] ea;
        logic       is_wr, has_op;
        int         lat, en_lat, n0;
        rand_jdo();
        ea = m_jaddr; is_wr = 1'b0; has_op = 1'b1;
        n0 = acc_addr.size();
        if (kind == 0) begin
            jdo[24:17] = addr; jdo[34] = rd; ea = addr; m_jaddr = addr; has_op = rd;
            take_action_ocimem_a = 1'b1;
        end else if (kind == 1) begin
            jdo[34:3] = data; is_wr = 1'b1;
            take_action_ocimem_b = 1'b1;
        end else begin
            take_no_action_ocimem_a = 1'b1;
        end
        step();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        if (!has_op) return;
        check({tag, " ready low N+1"}, monitor_ready, 1'b0);
        lat = 1; en_lat = 0;
        while (!monitor_ready && lat < 20) begin
            step();
            lat++;
            if (ram_en && en_lat == 0) en_lat = lat;
        end
        check({tag, " ram_en cycle"}, en_lat, 2);
        check({tag, " done cycle"}, lat, is_wr ? 3 : 4);
        check({tag, " access count"}, acc_addr.size(), n0 + 1);
        if (acc_addr.size() > n0) begin
            check({tag, " addr"}, acc_addr[n0], ea);
            check({tag, " we"}, acc_we[n0], is_wr);
            if (is_wr) check({tag, " wdata"}, acc_data[n0], data);
        end
        if (is_wr) ref_mem[ea] = data;
        else       check({tag, " MonDReg"}, MonDReg, ref_mem[ea]);
        m_jaddr = ea + 8'd1;
        m_last_jtag = 1'b1;
        step();
        check({tag, " ready held"}, monitor_ready, 1'b1);
    endtask

    // Starts and ends with FSM idle.
    task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = ref_mem[addr];
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = we; cpu_bus.cpu_addr = addr;
        cpu_bus.cpu_wdata = wd; cpu_bus.cpu_byteen = be;
        lat = 0;
        while (!cpu_bus.cpu_ack && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " ack latency"}, lat, we ? 2 : 3);
        if (we) ref_mem[addr] = merge(exp, wd, be);
        else    check({tag, " rdata"}, cpu_bus.cpu_rdata, exp);
        cpu_bus.cpu_req = 1'b0;
        m_last_jtag = 1'b0;
        step();
        check({tag, " ack one cycle"}, cpu_bus.cpu_ack, 1'b0);
    endtask

    initial begin
        int          n, acks;
        logic        first_jtag;
        logic [7:0]  ca, ja;
        logic [31:0] d, wd;
        logic [3:0]  be;

        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = '0;
        cpu_bus.cpu_wdata = '0; cpu_bus.cpu_byteen = '0;
        m_jaddr = 8'h00; m_last_jtag = 1'b0;
        step();
        for (int a = 0; a < 256; a++) preload(8'(a), $urandom);

        // Reset state
        check("rst ram_en", ram_en, 1'b0);
        check("rst cpu_ack", cpu_bus.cpu_ack, 1'b0);
        check("rst cpu_rdata", cpu_bus.cpu_rdata, 32'h0);
        check("rst MonDReg", MonDReg, 32'h0);
        check("rst monitor_ready", monitor_ready, 1'b0);
        check("rst overrun", jtag_overrun, 1'b0);
        do_reset();

        // Address load, write, read-next
        jtag_cmd(0, 8'h10, 1'b0, 32'h0, "t1 load");
        jtag_cmd(1, 8'h00, 1'b0, 32'hDEADBEEF, "t1 write");
        preload(8'h11, 32'h12345678);
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "t2 readnext");

        // Address wrap
        jtag_cmd(0, 8'hFF, 1'b0, 32'h0, "t4 load");
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "t4 read ff");
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "t4 read 00");

        // Contention straight after reset: round 1
        do_reset();
        acc_clear();
        d = $urandom;
        rand_jdo(); jdo[34:3] = d; take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 8'h20;
        cpu_bus.cpu_byteen = 4'hF;
        n = 0;
        while (!cpu_bus.cpu_ack && n < 30) begin step(); n++; end
        check("rr1 cpu ack", cpu_bus.cpu_ack, 1'b1);
        check("rr1 cpu rdata", cpu_bus.cpu_rdata, ref_mem[8'h20]);
        cpu_bus.cpu_req = 1'b0;
        step();
        first_jtag = !m_last_jtag;
        check("rr1 access count", acc_addr.size(), 2);
        if (acc_addr.size() >= 2) begin
            check("rr1 first addr", acc_addr[0], first_jtag ? m_jaddr : 8'h20);
            check("rr1 first we", acc_we[0], first_jtag);
            check("rr1 second addr", acc_addr[1], first_jtag ? 8'h20 : m_jaddr);
        end
        check("rr1 monitor_ready", monitor_ready, 1'b1);
        ref_mem[m_jaddr] = d;
        m_jaddr = m_jaddr + 8'd1;
        m_last_jtag = !first_jtag;

        // A lone JTAG access makes JTAG the last grant, so the next contest goes to the CPU.
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "rr mid");
        acc_clear();
        rand_jdo(); take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        ca = 8'h40 + 8'($urandom_range(0, 15));
        wd = $urandom; be = 4'($urandom_range(1, 15));
        ja = m_jaddr;
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b1; cpu_bus.cpu_addr = ca;
        cpu_bus.cpu_wdata = wd; cpu_bus.cpu_byteen = be;
        n = 0;
        while (!cpu_bus.cpu_ack && n < 30) begin step(); n++; end
        check("rr2 cpu ack", cpu_bus.cpu_ack, 1'b1);
        cpu_bus.cpu_req = 1'b0;
        ref_mem[ca] = merge(ref_mem[ca], wd, be);
        n = 0;
        while (!monitor_ready && n < 30) begin step(); n++; end
        first_jtag = !m_last_jtag;
        check("rr2 access count", acc_addr.size(), 2);
        if (acc_addr.size() >= 2) begin
            check("rr2 first addr", acc_addr[0], first_jtag ? ja : ca);
            check("rr2 first we", acc_we[0], !first_jtag);
        end
        check("rr2 MonDReg", MonDReg, ref_mem[ja]);
        m_jaddr = ja + 8'd1;
        m_last_jtag = 1'b1;
        step();

        // Randomized CPU and JTAG traffic against the reference memory
        for (int i = 0; i < 6; i++) begin
            ca = 8'($urandom_range(0, 255));
            cpu_access(1'b1, ca, $urandom, 4'($urandom_range(1, 15)), "rnd cpu wr");
            cpu_access(1'b0, ca, 32'h0, 4'hF, "rnd cpu rd");
            jtag_cmd(0, 8'($urandom_range(0, 255)), 1'b1, 32'h0, "rnd jtag rd");
            jtag_cmd(1, 8'h00, 1'b0, $urandom, "rnd jtag wr");
            cpu_access(1'b0, m_jaddr - 8'd1, 32'h0, 4'hF, "rnd cpu rd jtag");
        end

        // Overrun: two ocimem_b back-to-back while the CPU holds the RAM
        acc_clear();
        ca = 8'h80 + 8'($urandom_range(0, 15));
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = ca;
        step();
        rand_jdo(); jdo[34:3] = 32'h1; take_action_ocimem_b = 1'b1;
        step();
        jdo[34:3] = 32'h2;
        step();
        take_action_ocimem_b = 1'b0;
        n = 0;
        while (!cpu_bus.cpu_ack && n < 30) begin step(); n++; end
        check("ovr cpu rdata", cpu_bus.cpu_rdata, ref_mem[ca]);
        cpu_bus.cpu_req = 1'b0;
        n = 0;
        while (!monitor_ready && n < 30) begin step(); n++; end
        check("ovr access count", acc_addr.size(), 2);
        if (acc_addr.size() >= 2) begin
            check("ovr write addr", acc_addr[1], m_jaddr);
            check("ovr write data", acc_data[1], 32'h2);
        end
        check("ovr flag", jtag_overrun, 1'b1);
        ref_mem[m_jaddr] = 32'h2;
        m_jaddr = m_jaddr + 8'd1;
        m_last_jtag = 1'b1;
        step();
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "ovr clean");
        check("ovr sticky", jtag_overrun, 1'b1);

        // Reset during WAIT of a CPU read
        ca = 8'($urandom_range(0, 255));
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = ca;
        step();
        step();
        reset = 1'b1;
        step();
        check("midrst cpu_ack", cpu_bus.cpu_ack, 1'b0);
        check("midrst ram_en", ram_en, 1'b0);
        check("midrst cpu_rdata", cpu_bus.cpu_rdata, 32'h0);
        check("midrst MonDReg", MonDReg, 32'h0);
        check("midrst monitor_ready", monitor_ready, 1'b0);
        check("midrst overrun", jtag_overrun, 1'b0);
        cpu_bus.cpu_req = 1'b0;
        reset = 1'b0;
        m_jaddr = 8'h00;
        m_last_jtag = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin step(); acks += int'(cpu_bus.cpu_ack); end
        check("midrst no late ack", acks, 0);
        cpu_access(1'b1, 8'h33, $urandom, 4'hF, "post rst cpu wr");
        jtag_cmd(2, 8'h00, 1'b0, 32'h0, "post rst jtag addr0");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
